// File: rtl/rf_read_scoreboard.sv
// 32x32 GPR file with two combinational read ports, one writeback port and a per-register
// pending-write scoreboard that interlocks ID issue; zero read latency, id_ready drops on RAW or counter overflow.
// Optional RF_SB_BYPASS_EN: same-cycle writeback forwarding to the read ports and early hazard release.
module rf_read_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    input  logic        use1,
    input  logic        use2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        id_valid,
    input  logic        id_wen,
    input  logic [4:0]  id_waddr,
    output logic        id_ready,
    input  logic        wb_wen,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic        flush,
    output logic        sb_busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      gpr_q [32];
    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];

    logic             issue;
    logic             haz1, haz2, ovf;
    logic [CNT_W-1:0] cnt1, cnt2;

    assign cnt1  = cnt_q[raddr1];
    assign cnt2  = cnt_q[raddr2];
    assign issue = id_valid & id_ready;

`ifdef RF_SB_BYPASS_EN
    logic wb_hit1, wb_hit2;
    assign wb_hit1 = wb_wen & (wb_waddr == raddr1) & (raddr1 != 5'd0);
    assign wb_hit2 = wb_wen & (wb_waddr == raddr2) & (raddr2 != 5'd0);
    // The last outstanding writer committing this cycle is forwarded, so no stall is needed.
    assign haz1   = use1 & (raddr1 != 5'd0) & (cnt1 != '0) & ~((cnt1 == CNT_ONE) & wb_hit1);
    assign haz2   = use2 & (raddr2 != 5'd0) & (cnt2 != '0) & ~((cnt2 == CNT_ONE) & wb_hit2);
    assign rdata1 = wb_hit1 ? wb_wdata : gpr_q[raddr1];
    assign rdata2 = wb_hit2 ? wb_wdata : gpr_q[raddr2];
`else
    assign haz1   = use1 & (raddr1 != 5'd0) & (cnt1 != '0);
    assign haz2   = use2 & (raddr2 != 5'd0) & (cnt2 != '0);
    assign rdata1 = gpr_q[raddr1];
    assign rdata2 = gpr_q[raddr2];
`endif

    assign ovf      = id_wen & (id_waddr != 5'd0) & (cnt_q[id_waddr] == CNT_MAX);
    assign id_ready = ~haz1 & ~haz2 & ~ovf;

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            logic inc, dec;
            inc = issue & id_wen & (id_waddr == r[4:0]) & (r != 0);
            dec = wb_wen & (wb_waddr == r[4:0]);
            cnt_d[r] = cnt_q[r];
            // Flush discards every in-flight reservation, including this cycle's issue.
            if (flush)
                cnt_d[r] = '0;
            else if (inc && !dec)
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            else if (dec && !inc && cnt_q[r] != '0)
                cnt_d[r] = cnt_q[r] - CNT_ONE;
        end
    end

    always_comb begin
        sb_busy = 1'b0;
        for (int r = 0; r < 32; r++)
            sb_busy = sb_busy | (cnt_q[r] != '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < 32; r++) begin
                gpr_q[r] <= '0;
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 32; r++)
                cnt_q[r] <= cnt_d[r];
            if (wb_wen && wb_waddr != 5'd0)
                gpr_q[wb_waddr] <= wb_wdata;
        end
    end

endmodule

// File: tb/tb_rf_read_scoreboard.sv
// Directed bench for rf_read_scoreboard: reset, RAW interlock, overflow, inc/dec collision, flush, r0.
module tb_rf_read_scoreboard;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  raddr1, raddr2, id_waddr, wb_waddr;
    logic        use1, use2, id_valid, id_wen, wb_wen, flush;
    logic [31:0] rdata1, rdata2, wb_wdata;
    logic        id_ready, sb_busy;

    int errors = 0;
    int checks = 0;

    rf_read_scoreboard #(.CNT_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .raddr1(raddr1), .raddr2(raddr2), .use1(use1), .use2(use2),
        .rdata1(rdata1), .rdata2(rdata2),
        .id_valid(id_valid), .id_wen(id_wen), .id_waddr(id_waddr), .id_ready(id_ready),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .flush(flush), .sb_busy(sb_busy)
    );

    always #5 clk = ~clk;

    task automatic idle();
        raddr1 = 0; raddr2 = 0; use1 = 0; use2 = 0;
        id_valid = 0; id_wen = 0; id_waddr = 0;
        wb_wen = 0; wb_waddr = 0; wb_wdata = 0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wen(input logic [4:0] rd);
        idle();
        id_valid = 1; id_wen = 1; id_waddr = rd;
        step();
    endtask

    task automatic test_reset();
        resetn = 0;
        idle();
        raddr1 = 5; use1 = 1;
        #2;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", id_ready); end
        checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", sb_busy); end
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata1); end
        @(posedge clk); #1 resetn = 1;
        idle();
        wb_wen = 1; wb_waddr = 5; wb_wdata = 32'hDEAD;
        step();
        issue_wen(5);
        issue_wen(5);
        idle();
        use1 = 1; raddr1 = 5;
        @(negedge clk);
        checks++; if (rdata1 !== 32'hDEAD) begin errors++; $display("FAIL pre_reset_rdata: got %h want dead", rdata1); end
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_stall: got %b want 0", id_ready); end
        checks++; if (sb_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %b want 1", sb_busy); end
        #1 resetn = 0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h want 0", rdata1); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", id_ready); end
        checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", sb_busy); end
        @(posedge clk); #1 resetn = 1;
        @(negedge clk);
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL postrst_ready: got %b want 1", id_ready); end
        step();
    endtask

    task automatic test_raw();
        idle();
        id_valid = 1; id_wen = 1; id_waddr = 8;
        @(negedge clk);
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL raw_issue_ready: got %b want 1", id_ready); end
        step();
        idle();
        id_valid = 1; use1 = 1; raddr1 = 8;
        @(negedge clk);
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL raw_stall0: got %b want 0", id_ready); end
        checks++; if (sb_busy !== 1'b1) begin errors++; $display("FAIL raw_busy: got %b want 1", sb_busy); end
        step();
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL raw_stall1: got %b want 0", id_ready); end
        wb_wen = 1; wb_waddr = 8; wb_wdata = 32'h1234;
        @(negedge clk);
`ifdef RF_SB_BYPASS_EN
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_ready: got %b want 1", id_ready); end
        checks++; if (rdata1 !== 32'h1234) begin errors++; $display("FAIL raw_wb_rdata: got %h want 1234", rdata1); end
`else
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_ready: got %b want 0", id_ready); end
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL raw_wb_rdata: got %h want 0", rdata1); end
`endif
        step();
        wb_wen = 0;
        @(negedge clk);
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL raw_after_ready: got %b want 1", id_ready); end
        checks++; if (rdata1 !== 32'h1234) begin errors++; $display("FAIL raw_after_rdata: got %h want 1234", rdata1); end
        checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL raw_after_busy: got %b want 0", sb_busy); end
        step();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            idle();
            id_valid = 1; id_wen = 1; id_waddr = 3;
            @(negedge clk);
            checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL ovf_issue%0d: got %b want 1", i, id_ready); end
            step();
        end
        idle();
        id_valid = 1; id_wen = 1; id_waddr = 3;
        @(negedge clk);
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL ovf_stall: got %b want 0", id_ready); end
        step();
        wb_wen = 1; wb_waddr = 3; wb_wdata = 32'h33;
        @(negedge clk);
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL ovf_wb_cycle: got %b want 0", id_ready); end
        step();
        wb_wen = 0;
        @(negedge clk);
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL ovf_release: got %b want 1", id_ready); end
        step();
        @(negedge clk);
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL ovf_refull: got %b want 0", id_ready); end
        idle();
        flush = 1;
        step();
        flush = 0;
        @(negedge clk);
        checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL ovf_flush_busy: got %b want 0", sb_busy); end
        step();
    endtask

    task automatic test_simultaneous();
        issue_wen(7);
        idle();
        id_valid = 1; id_wen = 1; id_waddr = 7;
        wb_wen = 1; wb_waddr = 7; wb_wdata = 32'h77;
        @(negedge clk);
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL sim_ready: got %b want 1", id_ready); end
        step();
        idle();
        use2 = 1; raddr2 = 7;
        @(negedge clk);
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL sim_cnt_held: got %b want 0", id_ready); end
        checks++; if (rdata2 !== 32'h77) begin errors++; $display("FAIL sim_gpr: got %h want 77", rdata2); end
        step();
        wb_wen = 1; wb_waddr = 7; wb_wdata = 32'h78;
        step();
        wb_wen = 0;
        @(negedge clk);
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL sim_drained_ready: got %b want 1", id_ready); end
        checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL sim_drained_busy: got %b want 0", sb_busy); end
        step();
    endtask

    task automatic test_flush();
        issue_wen(2);
        issue_wen(9);
        issue_wen(9);
        idle();
        @(negedge clk);
        checks++; if (sb_busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %b want 1", sb_busy); end
        flush = 1;
        wb_wen = 1; wb_waddr = 2; wb_wdata = 32'hAA;
        id_valid = 1; id_wen = 1; id_waddr = 4;
        step();
        idle();
        use1 = 1; raddr1 = 2; use2 = 1; raddr2 = 9;
        @(negedge clk);
        checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", sb_busy); end
        checks++; if (rdata1 !== 32'hAA) begin errors++; $display("FAIL flush_gpr2: got %h want aa", rdata1); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", id_ready); end
        use2 = 1; raddr2 = 4;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_discard_issue: got %b want 1", id_ready); end
        step();
    endtask

    task automatic test_r0();
        idle();
        wb_wen = 1; wb_waddr = 0; wb_wdata = 32'hFFFF;
        id_valid = 1; id_wen = 1; id_waddr = 0;
        use1 = 1; raddr1 = 0; raddr2 = 8;
        @(negedge clk);
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL r0_rdata: got %h want 0", rdata1); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL r0_ready: got %b want 1", id_ready); end
        checks++; if (rdata2 !== 32'h1234) begin errors++; $display("FAIL r0_port2: got %h want 1234", rdata2); end
        step();
        idle();
        use1 = 1; raddr1 = 0;
        @(negedge clk);
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL r0_after_rdata: got %h want 0", rdata1); end
        checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL r0_busy: got %b want 0", sb_busy); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL r0_after_ready: got %b want 1", id_ready); end
        step();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_overflow();
        test_simultaneous();
        test_flush();
        test_r0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
